adc_lane_align: RTL and testbench
=================================

Name: adc_lane_align

Overview:
- Parametrised automatic lane-alignment engine for multi-lane LVDS ADC capture. Replaces fixed manual idelay/bitslip tuning.
- Sits between the config block (training_start/training_done, manual controls) and the per-lane ISERDES/IDELAY datapath, all in the rxclkdiv domain.
- For each lane in turn it sweeps the IDELAY taps against a known training word, centres the tap in the widest valid eye, then bitslips until the word is framed exactly.
- Reports per-lane taps, pass/fail flags and an aggregate rxdataisgood.

Parameters:
- NUM_CHAN, 16, number of serial lanes.
- DATA_W, 8, deserialisation factor (bits per lane per clk).
- TAP_W, 5, IDELAY tap counter width; taps swept 0..2^TAP_W-1.
- TRAIN_PATTERN, 8'hA5, DATA_W-bit training word expected on every lane.
- SETTLE_CYC, 16, wait cycles after any tap change or bitslip.
- CHECK_CYC, 64, consecutive compare cycles per tap/slip test.
- MIN_WIN, 4, minimum eye width (taps) for a lane to pass.

Ports:
- clk  in  1  rxclkdiv.
- rst_n  in  1  asynchronous, active-low reset.
- training_start  in  1  single-cycle start pulse.
- lane_data  in  NUM_CHAN*DATA_W  ISERDES parallel data; lane k occupies bits [k*DATA_W+:DATA_W].
- manual_enable  in  1  selects manual control while the FSM is idle.
- manual_chan_sel  in  clog2(NUM_CHAN)  manual lane select.
- manual_inc, manual_bitslip, manual_idly_rst  in  1 each  manual pulses.
- idly_chan_sel  out  clog2(NUM_CHAN)  lane addressed by the pulses below.
- idly_inc  out  1  one-cycle tap increment.
- idly_rst  out  1  one-cycle tap reset (tap becomes 0).
- idly_bitslip  out  1  one-cycle bitslip.
- training_done  out  1  high from sweep completion until the next start or reset.
- tap  out  NUM_CHAN*TAP_W  final centred tap per lane.
- lane_ok  out  NUM_CHAN  per-lane pass.
- rxdataisgood  out  1  AND of lane_ok, valid when training_done=1.

Behaviour:
- Reset (async assert, sync release): FSM enters IDLE. All outputs are 0, including tap, lane_ok, training_done and the pulses.
- IDLE:
  - manual_enable=1 routes manual_* to idly_* combinationally.
  - Otherwise idly_* pulses are 0 and idly_chan_sel holds its last value.
  - training_start with manual_enable=0 clears training_done, lane_ok and tap, sets ch=0 and goes to RST_DLY.
  - training_start is ignored outside IDLE or while manual_enable=1.
- RST_DLY: idly_rst pulses 1 cycle; cur_tap=0; window trackers cleared (cur_len=0, best_len=0); go to SETTLE.
- SETTLE: count SETTLE_CYC cycles, then go to CHECK.
- CHECK, CHECK_CYC cycles:
  - A tap is valid iff lane ch equals some rotation of TRAIN_PATTERN on every cycle.
  - If valid: cur_len++ and, when cur_len was 0, cur_start=cur_tap.
  - If invalid: cur_len=0.
  - Whenever the updated cur_len > best_len, the best window becomes (cur_start, cur_len). Strictly greater, so ties keep the earlier window.
  - If cur_tap < max, go to STEP; else go to CENTER.
- STEP: idly_inc pulses 1 cycle, cur_tap++, go to SETTLE.
- CENTER:
  - If best_len < MIN_WIN: lane_ok[ch]=0, tap[ch]=0, go to NEXT_CH.
  - Otherwise target = best_start + (best_len>>1), floor. Pulse idly_rst, then issue target idly_inc pulses spaced 2 cycles apart. Write tap[ch]=target, slip=0, go to SLIP_SETTLE.
  - A window reaching the last tap is closed at sweep end; there is no wrap to tap 0.
- SLIP_SETTLE: wait SETTLE_CYC cycles, then go to SLIP_CHECK.
- SLIP_CHECK:
  - If lane equals TRAIN_PATTERN exactly for CHECK_CYC cycles: lane_ok[ch]=1, go to NEXT_CH.
  - Else if slip < DATA_W-1: pulse idly_bitslip, slip++, go to SLIP_SETTLE.
  - Else: lane_ok[ch]=0, go to NEXT_CH.
- NEXT_CH: if ch = NUM_CHAN-1, go to DONE; else ch++ and go to RST_DLY.
- DONE: training_done=1, rxdataisgood=&lane_ok, return to IDLE. training_done holds until the next start.
- idly_chan_sel=ch throughout training.
- Pulses are never concurrent: at most one of idly_inc, idly_rst, idly_bitslip is high in any cycle.
- Per-tap cost: 1 + SETTLE_CYC + CHECK_CYC cycles.

Test Plan:
- Lane model: IDELAY taps with a valid window at taps 10..19, data rotated so 5 slips are needed → tap[ch]=15, 5 idly_bitslip pulses, lane_ok=1. rxdataisgood=1 after all 16 lanes pass.
- Two windows, 2..5 and 20..27 → tap=24 (widest window wins); equal windows 2..5 and 20..23 → tap=4.
- Window 28..31 at sweep end → tap=30, lane_ok=1; window of 3 taps (< MIN_WIN) → lane_ok=0, tap=0, rxdataisgood=0.
- Pattern never framed exactly after 7 slips → lane_ok[ch]=0, sweep continues to the next lane, training_done=1.
- rst_n asserted mid-sweep (lane 7, CHECK) → all outputs 0 immediately. A second training_start mid-sweep is ignored. A new start after reset completes normally.
- manual_enable=1 in IDLE, manual_inc pulsed 3× on lane 2 → idly_inc follows, idly_chan_sel=2. training_start is ignored while manual_enable=1.

Source files
------------

// File: rtl/adc_lane_align.sv
// Per-lane IDELAY eye sweep, eye centring and bitslip framing against a fixed training word.
// Per tap 1+SETTLE_CYC+CHECK_CYC cycles; no backpressure, lanes are trained one after another.
module adc_lane_align #(
    parameter int                NUM_CHAN      = 16,
    parameter int                DATA_W        = 8,
    parameter int                TAP_W         = 5,
    parameter logic [DATA_W-1:0] TRAIN_PATTERN = 8'hA5,
    parameter int                SETTLE_CYC    = 16,
    parameter int                CHECK_CYC     = 64,
    parameter int                MIN_WIN       = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         training_start,
    input  logic [NUM_CHAN*DATA_W-1:0]   lane_data,
    input  logic                         manual_enable,
    input  logic [$clog2(NUM_CHAN)-1:0]  manual_chan_sel,
    input  logic                         manual_inc,
    input  logic                         manual_bitslip,
    input  logic                         manual_idly_rst,
    output logic [$clog2(NUM_CHAN)-1:0]  idly_chan_sel,
    output logic                         idly_inc,
    output logic                         idly_rst,
    output logic                         idly_bitslip,
    output logic                         training_done,
    output logic [NUM_CHAN*TAP_W-1:0]    tap,
    output logic [NUM_CHAN-1:0]          lane_ok,
    output logic                         rxdataisgood
);
    localparam int CH_W    = $clog2(NUM_CHAN);
    localparam int LEN_W   = TAP_W + 1;
    localparam int SLIP_W  = $clog2(DATA_W);
    localparam int CNT_MAX = (SETTLE_CYC > CHECK_CYC) ? SETTLE_CYC : CHECK_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_RST_DLY, S_SETTLE, S_CHECK, S_STEP, S_CENTER, S_CTR_GAP, S_CTR_INC,
        S_SLIP_SETTLE, S_SLIP_CHECK, S_SLIP, S_NEXT_CH, S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [CH_W-1:0]          ch_q, ch_d, sel_q, sel_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [TAP_W-1:0]         cur_tap_q, cur_tap_d, cur_start_q, cur_start_d;
    logic [TAP_W-1:0]         best_start_q, best_start_d, inc_q, inc_d;
    logic [LEN_W-1:0]         cur_len_q, cur_len_d, best_len_q, best_len_d;
    logic [SLIP_W-1:0]        slip_q, slip_d;
    logic                     err_q, err_d, done_q, done_d, good_q, good_d;
    logic [NUM_CHAN*TAP_W-1:0] tap_q, tap_d;
    logic [NUM_CHAN-1:0]      ok_q, ok_d;
    logic [DATA_W-1:0]        lane_w;
    logic [TAP_W-1:0]         target, start_nxt;
    logic [LEN_W-1:0]         len_nxt;
    logic                     err_now;

    // True when the word is any rotation of the training pattern (eye open, framing unknown).
    function automatic logic is_rot(input logic [DATA_W-1:0] w);
        logic [DATA_W-1:0] p;
        is_rot = 1'b0;
        p      = TRAIN_PATTERN;
        for (int r = 0; r < DATA_W; r++) begin
            if (w == p) is_rot = 1'b1;
            p = {p[DATA_W-2:0], p[DATA_W-1]};
        end
    endfunction

    assign lane_w        = lane_data[int'(ch_q)*DATA_W +: DATA_W];
    assign target        = best_start_q + TAP_W'(best_len_q >> 1);
    assign idly_chan_sel = (state_q == S_IDLE && manual_enable) ? manual_chan_sel : sel_q;
    assign training_done = done_q;
    assign tap           = tap_q;
    assign lane_ok       = ok_q;
    assign rxdataisgood  = good_q;

    always_comb begin
        state_d = state_q;  ch_d = ch_q;  sel_d = sel_q;  cnt_d = cnt_q;
        cur_tap_d = cur_tap_q;  cur_start_d = cur_start_q;  cur_len_d = cur_len_q;
        best_start_d = best_start_q;  best_len_d = best_len_q;  inc_d = inc_q;
        slip_d = slip_q;  err_d = err_q;  done_d = done_q;  good_d = good_q;
        tap_d = tap_q;  ok_d = ok_q;
        idly_inc = 1'b0;  idly_rst = 1'b0;  idly_bitslip = 1'b0;
        err_now = 1'b0;  len_nxt = '0;  start_nxt = '0;
        case (state_q)
            S_IDLE: begin
                if (manual_enable) begin
                    idly_inc     = manual_inc;
                    idly_rst     = manual_idly_rst;
                    idly_bitslip = manual_bitslip;
                    sel_d        = manual_chan_sel;
                end else if (training_start) begin
                    done_d  = 1'b0;  good_d = 1'b0;  ok_d = '0;  tap_d = '0;
                    ch_d    = '0;
                    state_d = S_RST_DLY;
                end
            end
            S_RST_DLY: begin
                idly_rst  = 1'b1;
                cur_tap_d = '0;  cur_start_d = '0;  cur_len_d = '0;
                best_start_d = '0;  best_len_d = '0;  cnt_d = '0;
                state_d   = S_SETTLE;
            end
            S_SETTLE, S_SLIP_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = (state_q == S_SETTLE) ? S_CHECK : S_SLIP_CHECK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CHECK: begin
                err_now = err_q | ~is_rot(lane_w);
                if (cnt_q == CNT_W'(CHECK_CYC - 1)) begin
                    cnt_d = '0;
                    err_d = 1'b0;
                    if (!err_now) begin
                        len_nxt     = cur_len_q + 1'b1;
                        start_nxt   = (cur_len_q == '0) ? cur_tap_q : cur_start_q;
                        cur_len_d   = len_nxt;
                        cur_start_d = start_nxt;
                        // Strict compare: an equal-width later window never displaces the earlier one.
                        if (len_nxt > best_len_q) begin
                            best_len_d   = len_nxt;
                            best_start_d = start_nxt;
                        end
                    end else begin
                        cur_len_d = '0;
                    end
                    state_d = (cur_tap_q == '1) ? S_CENTER : S_STEP;
                end else begin
                    err_d = err_now;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STEP: begin
                idly_inc  = 1'b1;
                cur_tap_d = cur_tap_q + 1'b1;
                state_d   = S_SETTLE;
            end
            S_CENTER: begin
                if (best_len_q < LEN_W'(MIN_WIN)) begin
                    ok_d[ch_q] = 1'b0;
                    tap_d[int'(ch_q)*TAP_W +: TAP_W] = '0;
                    state_d = S_NEXT_CH;
                end else begin
                    idly_rst = 1'b1;
                    inc_d    = target;
                    tap_d[int'(ch_q)*TAP_W +: TAP_W] = target;
                    slip_d   = '0;
                    state_d  = S_CTR_GAP;
                end
            end
            S_CTR_GAP: begin
                cnt_d   = '0;
                state_d = (inc_q == '0) ? S_SLIP_SETTLE : S_CTR_INC;
            end
            S_CTR_INC: begin
                idly_inc = 1'b1;
                inc_d    = inc_q - 1'b1;
                state_d  = S_CTR_GAP;
            end
            S_SLIP_CHECK: begin
                err_now = err_q | (lane_w != TRAIN_PATTERN);
                if (cnt_q == CNT_W'(CHECK_CYC - 1)) begin
                    cnt_d = '0;
                    err_d = 1'b0;
                    if (!err_now) begin
                        ok_d[ch_q] = 1'b1;
                        state_d    = S_NEXT_CH;
                    end else if (slip_q < SLIP_W'(DATA_W - 1)) begin
                        state_d = S_SLIP;
                    end else begin
                        ok_d[ch_q] = 1'b0;
                        state_d    = S_NEXT_CH;
                    end
                end else begin
                    err_d = err_now;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SLIP: begin
                idly_bitslip = 1'b1;
                slip_d       = slip_q + 1'b1;
                cnt_d        = '0;
                state_d      = S_SLIP_SETTLE;
            end
            S_NEXT_CH: begin
                if (ch_q == CH_W'(NUM_CHAN - 1)) begin
                    state_d = S_DONE;
                end else begin
                    ch_d    = ch_q + 1'b1;
                    state_d = S_RST_DLY;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                good_d  = &ok_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d != S_IDLE) sel_d = ch_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;  ch_q <= '0;  sel_q <= '0;  cnt_q <= '0;
            cur_tap_q <= '0;  cur_start_q <= '0;  cur_len_q <= '0;
            best_start_q <= '0;  best_len_q <= '0;  inc_q <= '0;
            slip_q <= '0;  err_q <= 1'b0;  done_q <= 1'b0;  good_q <= 1'b0;
            tap_q <= '0;  ok_q <= '0;
        end else begin
            state_q <= state_d;  ch_q <= ch_d;  sel_q <= sel_d;  cnt_q <= cnt_d;
            cur_tap_q <= cur_tap_d;  cur_start_q <= cur_start_d;  cur_len_q <= cur_len_d;
            best_start_q <= best_start_d;  best_len_q <= best_len_d;  inc_q <= inc_d;
            slip_q <= slip_d;  err_q <= err_d;  done_q <= done_d;  good_q <= good_d;
            tap_q <= tap_d;  ok_q <= ok_d;
        end
    end
endmodule

// File: tb/tb_adc_lane_align.sv
// Randomised lane-alignment bench: behavioural IDELAY/ISERDES lane model plus an eye-search reference.
module tb_adc_lane_align;
    localparam int         NCH  = 4;
    localparam int         DW   = 8;
    localparam int         TW   = 5;
    localparam int         MINW = 4;
    localparam logic [7:0] PAT  = 8'hA5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n, training_start, manual_enable;
    logic                manual_inc, manual_bitslip, manual_idly_rst;
    logic [1:0]          manual_chan_sel, idly_chan_sel;
    logic [NCH*DW-1:0]   lane_data;
    logic                idly_inc, idly_rst, idly_bitslip, training_done, rxdataisgood;
    logic [NCH*TW-1:0]   tap;
    logic [NCH-1:0]      lane_ok;

    adc_lane_align #(
        .NUM_CHAN(NCH), .DATA_W(DW), .TAP_W(TW), .TRAIN_PATTERN(PAT),
        .SETTLE_CYC(2), .CHECK_CYC(4), .MIN_WIN(MINW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .training_start(training_start), .lane_data(lane_data),
        .manual_enable(manual_enable), .manual_chan_sel(manual_chan_sel),
        .manual_inc(manual_inc), .manual_bitslip(manual_bitslip), .manual_idly_rst(manual_idly_rst),
        .idly_chan_sel(idly_chan_sel), .idly_inc(idly_inc), .idly_rst(idly_rst),
        .idly_bitslip(idly_bitslip), .training_done(training_done), .tap(tap),
        .lane_ok(lane_ok), .rxdataisgood(rxdataisgood)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Lane model: open taps, framing offset that each bitslip reduces, and lanes that never frame.
    logic [31:0] vmask[NCH];
    bit          never_fr[NCH];
    int          need[NCH];
    int          mtap[NCH];
    int          mslip[NCH];
    int          inc_seen = 0;

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        logic [7:0] y;
        y = x;
        for (int i = 0; i < n; i++) y = {y[6:0], y[7]};
        return y;
    endfunction

    function automatic bit is_rotation(input logic [7:0] x);
        for (int i = 0; i < 8; i++) if (x == rotl(PAT, i)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] win(input int s, input int e);
        logic [31:0] m;
        m = '0;
        for (int i = s; i <= e; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic drive_lanes();
        logic [7:0] w;
        int         off;
        for (int k = 0; k < NCH; k++) begin
            if (vmask[k][mtap[k]]) begin
                off = never_fr[k] ? 3 : (((need[k] - mslip[k]) % 8) + 8) % 8;
                w   = rotl(PAT, off);
            end else begin
                w = 8'($urandom);
                if (is_rotation(w)) w = 8'h00;
            end
            lane_data[k*DW +: DW] = w;
        end
    endtask

    always @(negedge clk) begin
        int s;
        int sel;
        s   = int'(idly_inc) + int'(idly_rst) + int'(idly_bitslip);
        sel = int'(idly_chan_sel);
        if (s > 0) chk("pulse_excl", 64'(s), 64'd1);
        if (idly_rst) mtap[sel] = 0;
        if (idly_inc) begin
            inc_seen++;
            if (mtap[sel] < 31) mtap[sel]++;
        end
        if (idly_bitslip) mslip[sel]++;
        drive_lanes();
    end

    // Reference: widest fully-open interval, earliest on ties, centred with floor.
    function automatic void ref_lane(input logic [31:0] m, input bit nev, input int nd,
                                     output int etap, output bit eok, output int eslip, output bit wok);
        int          bl, bs;
        logic [63:0] w;
        bl = 0;
        bs = 0;
        for (int l = 32; l >= 1 && bl == 0; l--)
            for (int s = 0; s + l <= 32 && bl == 0; s++) begin
                w = (64'd1 << l) - 64'd1;
                if (((64'(m) >> s) & w) == w) begin
                    bl = l;
                    bs = s;
                end
            end
        if (bl < MINW) begin
            etap = 0; eok = 1'b0; eslip = 0; wok = 1'b0;
        end else begin
            etap = bs + bl / 2; wok = 1'b1; eok = !nev; eslip = nev ? 7 : nd;
        end
    endfunction

    task automatic rand_lane(input int k);
        int s, l;
        s = $urandom_range(0, 27);
        l = $urandom_range(2, 12);
        vmask[k] = win(s, (s + l - 1 > 31) ? 31 : s + l - 1);
        if ($urandom_range(0, 1) == 1) begin
            s = $urandom_range(0, 28);
            l = $urandom_range(2, 10);
            vmask[k] = vmask[k] | win(s, (s + l - 1 > 31) ? 31 : s + l - 1);
        end
        need[k]     = $urandom_range(0, 7);
        never_fr[k] = ($urandom_range(0, 5) == 0);
    endtask

    task automatic start_pulse();
        for (int k = 0; k < NCH; k++) mslip[k] = 0;
        @(posedge clk); #1 training_start = 1'b1;
        @(posedge clk); #1 training_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!training_done && n < 6000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!training_done) chk({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic wait_sel(input string name, input int v);
        int n;
        n = 0;
        while (int'(idly_chan_sel) != v && n < 4000) begin
            @(posedge clk); #1;
            n++;
        end
        if (int'(idly_chan_sel) != v) chk({name, "_sel_timeout"}, 64'(idly_chan_sel), 64'(v));
    endtask

    task automatic check_run(input string name);
        int etap, eslip;
        bit eok, wok, all_ok;
        all_ok = 1'b1;
        for (int k = 0; k < NCH; k++) begin
            ref_lane(vmask[k], never_fr[k], need[k], etap, eok, eslip, wok);
            all_ok &= eok;
            chk($sformatf("%s_tap%0d", name, k), 64'(tap[k*TW +: TW]), 64'(etap));
            chk($sformatf("%s_ok%0d", name, k), 64'(lane_ok[k]), 64'(eok));
            chk($sformatf("%s_slips%0d", name, k), 64'(mslip[k]), 64'(eslip));
            if (wok) chk($sformatf("%s_dlytap%0d", name, k), 64'(mtap[k]), 64'(etap));
        end
        chk({name, "_done"}, 64'(training_done), 64'd1);
        chk({name, "_good"}, 64'(rxdataisgood), 64'(all_ok));
    endtask

    task automatic run_train(input string name);
        start_pulse();
        wait_done(name);
        check_run(name);
    endtask

    initial begin
        int inc0;
        rst_n = 1'b0; training_start = 1'b0; manual_enable = 1'b0; manual_chan_sel = '0;
        manual_inc = 1'b0; manual_bitslip = 1'b0; manual_idly_rst = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            vmask[k] = win(10, 19); need[k] = 5; never_fr[k] = 1'b0; mtap[k] = 0; mslip[k] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tap", 64'(tap), 64'd0);
        chk("rst_ok", 64'(lane_ok), 64'd0);
        chk("rst_done", 64'(training_done), 64'd0);
        chk("rst_good", 64'(rxdataisgood), 64'd0);
        chk("rst_pulses", 64'({idly_inc, idly_rst, idly_bitslip, idly_chan_sel}), 64'd0);
        rst_n = 1'b1;

        run_train("basic");

        vmask[0] = win(2, 5) | win(20, 27);
        vmask[1] = win(2, 5) | win(20, 23);
        vmask[2] = win(28, 31);
        vmask[3] = win(12, 14);
        for (int k = 0; k < NCH; k++) need[k] = $urandom_range(0, 7);
        run_train("windows");

        for (int k = 0; k < NCH; k++) rand_lane(k);
        vmask[1] = win(6, 15); never_fr[1] = 1'b1;
        run_train("noframe");

        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < NCH; k++) rand_lane(k);
            run_train($sformatf("rand%0d", r));
        end

        for (int k = 0; k < NCH; k++) rand_lane(k);
        vmask[0] = win(8, 16); never_fr[0] = 1'b0; need[0] = $urandom_range(1, 7);
        start_pulse();
        wait_sel("restart", 1);
        training_start = 1'b1;
        @(posedge clk); #1 training_start = 1'b0;
        chk("restart_ignored_sel", 64'(idly_chan_sel), 64'd1);
        wait_done("restart");
        check_run("restart");

        for (int k = 0; k < NCH; k++) rand_lane(k);
        vmask[0] = win(4, 12); never_fr[0] = 1'b0;
        vmask[1] = win(15, 24); never_fr[1] = 1'b0;
        start_pulse();
        wait_sel("midrst", 2);
        repeat (40) @(posedge clk);
        #1;
        chk("midrst_pre_ok", 64'(lane_ok[1:0]), 64'd3);
        rst_n = 1'b0;
        #1;
        chk("midrst_tap", 64'(tap), 64'd0);
        chk("midrst_ok", 64'(lane_ok), 64'd0);
        chk("midrst_done_good", 64'({training_done, rxdataisgood}), 64'd0);
        chk("midrst_pulses", 64'({idly_inc, idly_rst, idly_bitslip, idly_chan_sel}), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        run_train("after_rst");

        @(posedge clk); #1;
        manual_enable = 1'b1; manual_chan_sel = 2'd2;
        #1 chk("man_sel", 64'(idly_chan_sel), 64'd2);
        inc0 = inc_seen;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1 manual_inc = 1'b1;
            #1 chk("man_inc_follow", 64'(idly_inc), 64'd1);
            @(posedge clk); #1 manual_inc = 1'b0;
        end
        @(posedge clk); #1;
        chk("man_inc_count", 64'(inc_seen - inc0), 64'd3);
        training_start = 1'b1;
        @(posedge clk); #1 training_start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("man_start_ignored", 64'(training_done), 64'd1);
        manual_enable = 1'b0; manual_inc = 1'b1;
        #1;
        chk("idle_sel_hold", 64'(idly_chan_sel), 64'd2);
        chk("idle_no_pulse", 64'(idly_inc), 64'd0);
        manual_inc = 1'b0;
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
